// File: rtl/life_step_engine.sv
// Serial Game-of-Life step engine: snapshots the grid on start, evaluates one
// cell per clock, and publishes the full next generation with a done pulse.
module life_step_engine #(
   parameter int ROWS  = 8,
   parameter int COLS  = 8,
   parameter int WIDTH = 64,
   parameter int WRAP  = 0,
   parameter int GEN_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] grid_in,
   output logic [WIDTH-1:0] grid_out,
   output logic             busy,
   output logic             done,
   output logic [GEN_W-1:0] gen_count
);
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {IDLE, SCAN} state_t;

   state_t           state;
   logic [IDX_W-1:0] index;
   logic [WIDTH-1:0] snapshot;
   logic [WIDTH-1:0] accum;
   logic [WIDTH-1:0] accum_next;
   logic [3:0]       ncount;
   logic             next_cell;
   logic             last_cell;
   logic [IDX_W-1:0] nidx;
   int               row;
   int               col;
   int               nr;
   int               nc;

   // Neighbours always come from the frozen snapshot, never the partial result.
   always_comb begin
      row    = int'(index) / COLS;
      col    = int'(index) % COLS;
      ncount = '0;
      nr     = 0;
      nc     = 0;
      nidx   = '0;
      for (int dr = -1; dr <= 1; dr++) begin
         for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
               nr = row + dr;
               nc = col + dc;
               if (WRAP != 0) begin
                  nr = (nr + ROWS) % ROWS;
                  nc = (nc + COLS) % COLS;
               end
               if (nr >= 0 && nr < ROWS && nc >= 0 && nc < COLS) begin
                  nidx   = IDX_W'(nr * COLS + nc);
                  ncount = ncount + 4'(snapshot[nidx]);
               end
            end
         end
      end
      next_cell = snapshot[index] ? (ncount == 4'd2 || ncount == 4'd3)
                                  : (ncount == 4'd3);
      accum_next        = accum;
      accum_next[index] = next_cell;
      last_cell         = (index == IDX_W'(WIDTH - 1));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         index     <= '0;
         snapshot  <= '0;
         accum     <= '0;
         grid_out  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         gen_count <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  snapshot <= grid_in;
                  accum    <= '0;
                  index    <= '0;
                  busy     <= 1'b1;
                  state    <= SCAN;
               end
            end
            SCAN: begin
               accum <= accum_next;
               if (last_cell) begin
                  grid_out  <= accum_next;
                  done      <= 1'b1;
                  gen_count <= gen_count + 1'b1;
                  busy      <= 1'b0;
                  index     <= '0;
                  state     <= IDLE;
               end else begin
                  index <= index + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_life_step_engine.sv
// Bench for life_step_engine: a clamped-edge and a toroidal instance run side by
// side against a generation-level model, plus hand-computed pattern checks.
module tb_life_step_engine;
   localparam int ROWS  = 8;
   localparam int COLS  = 8;
   localparam int WIDTH = 64;
   localparam logic [63:0] BLK      = 64'h0000_0008_0808_0000;
   localparam logic [63:0] BLK_NEXT = 64'h0000_0000_1C00_0000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [63:0] grid_in = '0;
   logic [63:0] grid_out0, grid_out1;
   logic        busy0, busy1, done0, done1;
   logic [15:0] gen0;
   logic [2:0]  gen1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   life_step_engine #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH), .WRAP(0), .GEN_W(16)) dut0 (
      .clk(clk), .reset(reset), .start(start), .grid_in(grid_in),
      .grid_out(grid_out0), .busy(busy0), .done(done0), .gen_count(gen0)
   );

   life_step_engine #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH), .WRAP(1), .GEN_W(3)) dut1 (
      .clk(clk), .reset(reset), .start(start), .grid_in(grid_in),
      .grid_out(grid_out1), .busy(busy1), .done(done1), .gen_count(gen1)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Next generation straight from the Life rules on a 2-D view of the grid.
   function automatic logic [63:0] life_next(input logic [63:0] g, input bit wrap);
      logic [63:0] n;
      int cnt, rr, cc;
      n = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  if (dr != 0 || dc != 0) begin
                     rr = r + dr;
                     cc = c + dc;
                     if (wrap) begin
                        rr = (rr + ROWS) % ROWS;
                        cc = (cc + COLS) % COLS;
                     end
                     if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS && g[rr*COLS+cc])
                        cnt++;
                  end
               end
            end
            if (g[r*COLS+c]) n[r*COLS+c] = (cnt == 2 || cnt == 3);
            else             n[r*COLS+c] = (cnt == 3);
         end
      end
      return n;
   endfunction

   // Model: a step accepted at an edge publishes its result WIDTH edges later.
   logic        m_busy[2];
   logic        m_done[2];
   int          m_cnt[2];
   int          m_gen[2];
   logic [63:0] m_next[2];
   logic [63:0] m_out[2];

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int d = 0; d < 2; d++) begin
            m_busy[d] = 1'b0; m_done[d] = 1'b0; m_cnt[d] = 0;
            m_gen[d]  = 0;    m_next[d] = '0;   m_out[d] = '0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            m_done[d] = 1'b0;
            if (m_busy[d]) begin
               m_cnt[d]--;
               if (m_cnt[d] == 0) begin
                  m_out[d]  = m_next[d];
                  m_done[d] = 1'b1;
                  m_gen[d]  = (m_gen[d] + 1) % ((d == 0) ? 65536 : 8);
                  m_busy[d] = 1'b0;
               end
            end else if (start) begin
               m_next[d] = life_next(grid_in, d == 1);
               m_busy[d] = 1'b1;
               m_cnt[d]  = WIDTH;
            end
         end
      end
   end

   always @(negedge clk) begin
      chk("busy0", 64'(busy0), 64'(m_busy[0]));
      chk("done0", 64'(done0), 64'(m_done[0]));
      chk("grid_out0", grid_out0, m_out[0]);
      chk("gen0", 64'(gen0), 64'(m_gen[0]));
      chk("busy1", 64'(busy1), 64'(m_busy[1]));
      chk("done1", 64'(done1), 64'(m_done[1]));
      chk("grid_out1", grid_out1, m_out[1]);
      chk("gen1", 64'(gen1), 64'(m_gen[1]));
   end

   task automatic pulse_reset();
      @(posedge clk); #2 reset = 1'b1;
      @(posedge clk); #2 reset = 1'b0;
   endtask

   task automatic step_lit(input string tag, input logic [63:0] g,
                           input logic [63:0] e0, input logic [63:0] e1);
      int lat;
      @(negedge clk); grid_in = g; start = 1'b1;
      @(negedge clk); start = 1'b0;
      lat = 0;
      while (done0 !== 1'b1 && lat < 200) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'd64);
      chk({tag, "_done1"}, 64'(done1), 64'd1);
      chk({tag, "_out0"}, grid_out0, e0);
      chk({tag, "_out1"}, grid_out1, e1);
   endtask

   initial begin
      int c, nd, dcyc;
      repeat (2) @(negedge clk);
      chk("rst_grid_out", grid_out0, 64'd0);
      chk("rst_busy", 64'(busy0), 64'd0);
      chk("rst_gen", 64'(gen0), 64'd0);
      @(posedge clk); #2 reset = 1'b0;

      step_lit("blinker1", BLK, BLK_NEXT, BLK_NEXT);
      chk("blinker1_gen", 64'(gen0), 64'd1);
      step_lit("blinker2", BLK_NEXT, BLK, BLK);
      chk("blinker2_gen", 64'(gen0), 64'd2);
      step_lit("block", 64'h303, 64'h303, 64'h303);
      step_lit("empty", 64'h0, 64'h0, 64'h0);
      step_lit("edge", 64'h83, 64'h0, 64'h0100_0000_0000_0101);

      // Busy protection: extra start and grid change mid-scan are ignored.
      pulse_reset();
      @(negedge clk); grid_in = BLK; start = 1'b1;
      @(negedge clk); start = 1'b0;
      c = 0; nd = 0; dcyc = -1;
      while (c < 100) begin
         @(negedge clk);
         c++;
         if (c == 10) start = 1'b1;
         if (c == 11) start = 1'b0;
         if (c == 20) grid_in = 64'hFFFF_0000_FFFF_0000;
         if (done0) begin
            nd++;
            if (dcyc < 0) dcyc = c;
         end
      end
      chk("busy_prot_pulses", 64'(nd), 64'd1);
      chk("busy_prot_cycle", 64'(dcyc), 64'd64);
      chk("busy_prot_out", grid_out0, BLK_NEXT);
      chk("busy_prot_gen", 64'(gen0), 64'd1);

      // Back-to-back with start held high and the result fed back.
      pulse_reset();
      @(negedge clk); grid_in = BLK; start = 1'b1;
      c = -1; nd = 0;
      while (c < 300 && nd < 2) begin
         @(negedge clk);
         c++;
         if (done0) begin
            nd++;
            if (nd == 1) begin
               chk("b2b_cycle1", 64'(c), 64'd64);
               chk("b2b_out1", grid_out0, BLK_NEXT);
               grid_in = grid_out0 === BLK_NEXT ? BLK_NEXT : BLK_NEXT;
            end else begin
               chk("b2b_cycle2", 64'(c), 64'd129);
               chk("b2b_out2", grid_out0, BLK);
               start = 1'b0;
            end
         end
      end
      start = 1'b0;
      chk("b2b_pulses", 64'(nd), 64'd2);
      chk("b2b_gen", 64'(gen0), 64'd2);

      // Reset in the middle of a scan clears everything and suppresses done.
      pulse_reset();
      step_lit("pre_abort", BLK, BLK_NEXT, BLK_NEXT);
      @(negedge clk); grid_in = BLK; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (29) @(negedge clk);
      @(posedge clk); #2 reset = 1'b1;
      #1;
      chk("abort_busy", 64'(busy0), 64'd0);
      chk("abort_done", 64'(done0), 64'd0);
      chk("abort_grid_out", grid_out0, 64'd0);
      chk("abort_gen", 64'(gen0), 64'd0);
      @(posedge clk); #2 reset = 1'b0;
      nd = 0;
      repeat (100) begin
         @(negedge clk);
         if (done0) nd++;
      end
      chk("abort_no_done", 64'(nd), 64'd0);
      step_lit("post_abort", BLK, BLK_NEXT, BLK_NEXT);
      chk("post_abort_gen", 64'(gen0), 64'd1);

      // Random traffic: start pulses, grid noise and rare resets.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #2;
         if ($urandom_range(0, 999) == 0) begin
            reset = 1'b1; start = 1'b0;
            @(posedge clk); #2 reset = 1'b0;
         end
         start = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 2))
               0:       grid_in = {$urandom, $urandom};
               1:       grid_in = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
               default: grid_in = 64'h0000_0000_0007_0507 << $urandom_range(0, 40);
            endcase
         end
      end
      start = 1'b0;
      repeat (80) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
